usb_ep_in_rr_arbiter: RTL

Packet-locking arbiter between N USB IN endpoint FIFOs and the single IN transmit byte stream of the USB device core. It is the parametrised successor to the combinational find-first-set IN arbiter. Additions over that arbiter:
- registered one-hot grant held for a whole packet;
- selectable fixed-priority or round-robin winner selection;
- configurable data width;
- max-packet-size byte counter with last-byte flag and forced release;
- abort indication when the granted endpoint withdraws mid-packet.

---
 rtl/usb_ep_in_rr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/usb_ep_in_rr_arbiter.sv
// rtl/usb_ep_in_rr_arbiter.sv - packet-locking IN endpoint arbiter, fixed-priority or round-robin
module usb_ep_in_rr_arbiter #(
    parameter int N_EP_IN = 2,
    parameter int DATA_W  = 8,
    parameter int RR      = 1,
    parameter int MAX_PKT = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_EP_IN-1:0]          i_inEp_req,
    input  logic [N_EP_IN*DATA_W-1:0]   i_inEp_data,
    output logic [N_EP_IN-1:0]          o_inEp_grant,
    output logic [N_EP_IN-1:0]          o_inEp_pop,
    output logic                        o_inTx_valid,
    output logic [DATA_W-1:0]           o_inTx_data,
    output logic                        o_inTx_last,
    output logic                        o_inTx_abort,
    input  logic                        i_inTx_ready,
    input  logic                        i_inTx_done
);

    localparam int CNT_W = $clog2(MAX_PKT + 1);
    localparam int PTR_W = (N_EP_IN > 1) ? $clog2(N_EP_IN) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [N_EP_IN-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic [PTR_W-1:0]   g_idx;
    logic               req_g;
    logic [DATA_W-1:0]  data_g;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [N_EP_IN-1:0] win_oh;
    logic               cnt_last;
    logic               accept;
    logic               abort_cond;
    logic               release_pkt;

    // Grant is one-hot, so an OR-reduction mux selects the granted endpoint.
    always_comb begin
        g_idx  = '0;
        data_g = '0;
        for (int j = 0; j < N_EP_IN; j++) begin
            if (grant_q[j]) begin
                g_idx = PTR_W'(j);
            end
            data_g = data_g | ({DATA_W{grant_q[j]}} & i_inEp_data[j*DATA_W +: DATA_W]);
        end
    end

    assign req_g = |(grant_q & i_inEp_req);

    // Round-robin searches upward from ptr+1 so the last winner goes to the back.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (RR != 0 && N_EP_IN > 1) begin
            for (int k = 1; k <= N_EP_IN; k++) begin
                if (!win_found && i_inEp_req[(int'(ptr_q) + k) % N_EP_IN]) begin
                    win_found = 1'b1;
                    win_idx   = PTR_W'((int'(ptr_q) + k) % N_EP_IN);
                end
            end
        end else begin
            for (int j = N_EP_IN - 1; j >= 0; j--) begin
                if (i_inEp_req[j]) begin
                    win_idx = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int j = 0; j < N_EP_IN; j++) begin
            win_oh[j] = (win_idx == PTR_W'(j));
        end
    end

    assign cnt_last    = (cnt_q == CNT_W'(MAX_PKT - 1));
    assign accept      = req_g && i_inTx_ready;
    // done takes precedence over a withdrawn request
    assign abort_cond  = (state_q == LOCKED) && !req_g && (cnt_q != '0) && !i_inTx_done;
    assign release_pkt = (state_q == LOCKED) && (i_inTx_done || (accept && cnt_last) || abort_cond);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|i_inEp_req) begin
                    state_d = LOCKED;
                    grant_d = win_oh;
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = g_idx;
                end else if (accept && !cnt_last) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_inEp_grant = grant_q;
    assign o_inEp_pop   = i_inTx_ready ? (grant_q & i_inEp_req) : '0;
    assign o_inTx_valid = req_g;
    assign o_inTx_data  = data_g;
    assign o_inTx_last  = req_g && cnt_last;
    assign o_inTx_abort = abort_cond;

endmodule
